spi_bus_queued_master: RTL and testbench

// - Parametrised SPI master for CMOS-sensor register access. Generalises the fixed 9-bit-address/16-bit-data SPI_BUS.
// - Adds a command FIFO so init sequences can be queued back-to-back, a ready/valid command handshake,
//   a read-data return strobe, and a programmable SCLK divider and inter-frame gap.
// - Sits between the sensor-configuration sequencer and the sensor SPI pins.

---
 rtl/spi_bus_queued_master_pkg.sv | 22 ++
 rtl/spi_bus_queued_master_fifo.sv | 58 +++++
 rtl/spi_bus_queued_master.sv | 197 +++++++++++++++++++
 tb/tb_spi_bus_queued_master.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bus_queued_master_pkg.sv
// Shared types and sizing helpers for the queued SPI register-access master.
package spi_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // Serial frame: address, write flag, data.
    function automatic int frame_bits(input int addr_w, input int data_w);
        return addr_w + 1 + data_w;
    endfunction

    // Queued command word: {write, addr, wdata}.
    function automatic int cmd_bits(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_bus_queued_master_fifo.sv
// Synchronous command FIFO with registered full, empty and level flags.
module spi_cmd_fifo
    import spi_bus_pkg::*;
#(
    parameter  int WIDTH = 26,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;
    assign level_d = level_q + {{(LVL_W-1){1'b0}}, push_ok} - {{(LVL_W-1){1'b0}}, pop_ok};

    // NOTE: the storage array has no reset; only pointers and flags define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == LVL_W'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/spi_bus_queued_master.sv
// Queued SPI mode-0 master: commands are buffered in a FIFO and serialised as
// {addr, W, data} frames; read frames return the MISO data with a one-cycle strobe.
module spi_bus_queued_master
    import spi_bus_pkg::*;
#(
    parameter  int ADDR_W     = 9,
    parameter  int DATA_W     = 16,
    parameter  int CLK_DIV    = 2,
    parameter  int FIFO_DEPTH = 8,
    parameter  int SS_GAP     = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_input,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              SCLK,
    output logic              SS_N,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int FB      = frame_bits(ADDR_W, DATA_W);
    localparam int CMD_W   = cmd_bits(ADDR_W, DATA_W);
    localparam int CNT_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FB + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((SS_GAP > 1) ? SS_GAP - 2 : 0);
    localparam logic [BIT_W-1:0] DATA_START = BIT_W'(ADDR_W + 1);
    localparam logic [BIT_W-1:0] BITS_DONE  = BIT_W'(FB);

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [FB-1:0]     tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_read_q, is_read_d;
    logic              sclk_q, sclk_d, ss_n_q, ss_n_d, mosi_q, mosi_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [CMD_W-1:0]  head;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [FB-1:0]     head_frame;

    spi_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk_input),
        .rst_n   (reset_n),
        .push_i  (cmd_valid),
        .pop_i   (pop),
        .wdata_i ({cmd_write, cmd_addr, cmd_wdata}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Read frames shift zeros during the data phase.
    assign head_write = head[CMD_W-1];
    assign head_addr  = head[CMD_W-2 -: ADDR_W];
    assign head_frame = {head_addr, head_write, head_write ? head[DATA_W-1:0] : {DATA_W{1'b0}}};

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        addr_d     = addr_q;
        is_read_d  = is_read_q;
        sclk_d     = sclk_q;
        ss_n_d     = ss_n_q;
        mosi_d     = mosi_q;
        rd_valid_d = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    ss_n_d    = 1'b0;
                    tx_d      = head_frame;
                    mosi_d    = head_frame[FB-1];
                    addr_d    = head_addr;
                    is_read_d = !head_write;
                    bit_d     = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[FB-2];
                        bit_d  = bit_q + 1'b1;
                    end else if (bit_q == BITS_DONE) begin
                        state_d = HOLD;
                    end else begin
                        // Rising edge: MISO has been stable since the previous falling edge.
                        sclk_d = 1'b1;
                        if (bit_q >= DATA_START) rx_d = {rx_q[DATA_W-2:0], MISO};
                    end
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    ss_n_d  = 1'b1;
                    state_d = (SS_GAP > 1) ? GAP : IDLE;
                    if (is_read_q) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = addr_q;
                        rd_data_d  = rx_q;
                    end
                end
            end
            GAP: begin
                // The IDLE cycle that pops the next entry is the last high cycle of the gap.
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_input or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            addr_q     <= '0;
            is_read_q  <= 1'b0;
            sclk_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            addr_q     <= addr_d;
            is_read_q  <= is_read_d;
            sclk_q     <= sclk_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = !ss_n_q || !fifo_empty;
    assign rd_valid  = rd_valid_q;
    assign rd_addr   = rd_addr_q;
    assign rd_data   = rd_data_q;
    assign SCLK      = sclk_q;
    assign SS_N      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_bus_queued_master.sv
// Self-checking bench: a timeline model of frames predicts every output each cycle,
// and directed tests pin the model with hand-computed literals.
module tb_spi_bus_queued_master;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 16;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int SS_GAP     = 4;
    localparam int FB         = ADDR_W + 1 + DATA_W;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int FRAME_LEN  = CLK_DIV * (2 * FB + 2);

    logic              clk_input = 1'b0;
    logic              reset_n   = 1'b0;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic [LVL_W-1:0]  fifo_level;
    logic              SCLK, SS_N, MOSI;
    logic              MISO;

    spi_bus_queued_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH), .SS_GAP(SS_GAP)
    ) dut (
        .clk_input (clk_input),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .fifo_level(fifo_level),
        .SCLK      (SCLK),
        .SS_N      (SS_N),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk_input = ~clk_input;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] miso;
    } cmd_t;

    cmd_t              m_q[$];
    cmd_t              m_cur;
    bit                m_active = 1'b0;
    bit                m_acc;
    int                m_t0 = 0;
    int                m_tfree = 0;
    logic              exp_rd_valid = 1'b0;
    logic [ADDR_W-1:0] exp_rd_addr = '0;
    logic [DATA_W-1:0] exp_rd_data = '0;
    logic [DATA_W-1:0] miso_word = '0;

    function automatic logic frame_bit(input cmd_t c, input int b);
        logic [FB-1:0] w;
        w = {c.addr, c.write, c.write ? c.wdata : {DATA_W{1'b0}}};
        return w[FB-1-b];
    endfunction

    // Frames start at max(command available, previous end + gap) and last FRAME_LEN cycles.
    always @(posedge clk_input or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_active     = 1'b0;
            cyc          = 0;
            m_tfree      = 0;
            exp_rd_valid = 1'b0;
            exp_rd_addr  = '0;
            exp_rd_data  = '0;
        end else begin
            m_acc = cmd_valid && (m_q.size() < FIFO_DEPTH);
            cyc++;
            exp_rd_valid = 1'b0;
            if (m_active && cyc == m_t0 + FRAME_LEN) begin
                m_active = 1'b0;
                m_tfree  = cyc + SS_GAP;
                if (!m_cur.write) begin
                    exp_rd_valid = 1'b1;
                    exp_rd_addr  = m_cur.addr;
                    exp_rd_data  = m_cur.miso;
                end
            end
            if (!m_active && m_q.size() > 0 && cyc >= m_tfree) begin
                m_cur    = m_q.pop_front();
                m_active = 1'b1;
                m_t0     = cyc;
            end
            if (m_acc) m_q.push_back('{cmd_write, cmd_addr, cmd_wdata, miso_word});
        end
    end

    // ---------------- compare process and frame monitor ----------------
    logic          exp_ss, exp_sclk, exp_mosi;
    int            o, p, b;
    logic          prev_ss = 1'b1, prev_sclk = 1'b0;
    int            low_len = 0, high_len = 0, rises = 0;
    int            last_len = 0, last_rises = 0, last_gap = 0;
    int            ss_falls = 0, rd_pulses = 0;
    logic [FB-1:0] mosi_bits = '0, last_bits = '0;

    always @(negedge clk_input) begin
        if (reset_n) begin
            exp_ss = 1'b1; exp_sclk = 1'b0; exp_mosi = 1'b0;
            if (m_active) begin
                exp_ss = 1'b0;
                o = cyc - m_t0;
                if (o < CLK_DIV) begin
                    exp_mosi = frame_bit(m_cur, 0);
                end else if (o < CLK_DIV + 2 * CLK_DIV * FB) begin
                    p = o - CLK_DIV;
                    b = p / (2 * CLK_DIV);
                    exp_sclk = (p % (2 * CLK_DIV)) < CLK_DIV;
                    if (exp_sclk)        exp_mosi = frame_bit(m_cur, b);
                    else if (b + 1 < FB) exp_mosi = frame_bit(m_cur, b + 1);
                end
            end
            check("ss_n",       32'(SS_N),       32'(exp_ss));
            check("sclk",       32'(SCLK),       32'(exp_sclk));
            check("mosi",       32'(MOSI),       32'(exp_mosi));
            check("cmd_ready",  32'(cmd_ready),  32'(m_q.size() < FIFO_DEPTH));
            check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
            check("busy",       32'(busy),       32'(m_active || m_q.size() > 0));
            check("rd_valid",   32'(rd_valid),   32'(exp_rd_valid));
            check("rd_addr",    32'(rd_addr),    32'(exp_rd_addr));
            check("rd_data",    32'(rd_data),    32'(exp_rd_data));

            if (!SS_N) begin
                if (prev_ss) begin
                    last_gap = high_len; low_len = 0; rises = 0; mosi_bits = '0; ss_falls++;
                end
                low_len++;
                if (SCLK && !prev_sclk) begin
                    rises++;
                    mosi_bits = {mosi_bits[FB-2:0], MOSI};
                end
            end else begin
                if (!prev_ss) begin
                    last_len = low_len; last_rises = rises; last_bits = mosi_bits; high_len = 0;
                end
                high_len++;
            end
            if (rd_valid) rd_pulses++;
            prev_ss   = SS_N;
            prev_sclk = SCLK;
        end
    end

    // Slave model: shifts miso_word out MSB first on SCLK falling edges in the data phase.
    int fall_cnt = 0;
    always @(negedge SCLK or posedge SS_N) begin
        if (SS_N) begin
            fall_cnt = 0;
        end else begin
            fall_cnt++;
            if (fall_cnt >= ADDR_W + 1 && fall_cnt < FB)
                MISO = miso_word[DATA_W-1-(fall_cnt-ADDR_W-1)];
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_input);
    endtask

    task automatic push(input logic w, input int a, input int d);
        int guard = 0;
        cmd_valid = 1'b1; cmd_write = w;
        cmd_addr  = ADDR_W'(a); cmd_wdata = DATA_W'(d);
        while (!cmd_ready && guard < 3000) begin
            @(negedge clk_input);
            guard++;
        end
        if (guard >= 3000) fail_now("push_wait");
        @(negedge clk_input);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int guard = 0;
        @(negedge clk_input);
        while ((busy || !SS_N) && guard < 3000) begin
            @(negedge clk_input);
            guard++;
        end
        if (guard >= 3000) fail_now(name);
        tick(SS_GAP + 2);
    endtask

    logic [FB-1:0] exp_bits;
    int falls0, pulses0, acc, guard;

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; MISO = 1'b0;
        tick(3);
        check("rst_ss_n",       32'(SS_N),       32'd1);
        check("rst_sclk",       32'(SCLK),       32'd0);
        check("rst_mosi",       32'(MOSI),       32'd0);
        check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        check("rst_rd_valid",   32'(rd_valid),   32'd0);
        check("rst_rd_addr",    32'(rd_addr),    32'd0);
        check("rst_rd_data",    32'(rd_data),    32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Write 0x199 / 0xAAAA with the one-edge pop latency.
        pulses0 = rd_pulses;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h199; cmd_wdata = 16'hAAAA;
        @(negedge clk_input);
        cmd_valid = 1'b0;
        check("lat_accept_ss_n",  32'(SS_N),       32'd1);
        check("lat_accept_level", 32'(fifo_level), 32'd1);
        @(negedge clk_input);
        check("lat_pop_ss_n",     32'(SS_N),       32'd0);
        check("lat_pop_level",    32'(fifo_level), 32'd0);
        wait_quiet("wr_done");
        exp_bits = 26'b1100110011_1010101010101010;
        check("wr_ss_low_len", 32'(last_len),   32'd108);
        check("wr_sclk_rises", 32'(last_rises), 32'd26);
        check("wr_mosi_bits",  32'(last_bits),  32'(exp_bits));
        check("wr_no_rd",      32'(rd_pulses - pulses0), 32'd0);

        // Read 0x199 with MISO held high.
        pulses0 = rd_pulses;
        miso_word = 16'hFFFF; MISO = 1'b1;
        push(1'b0, 'h199, 'h0);
        wait_quiet("rd1_done");
        exp_bits = 26'b1100110010_0000000000000000;
        check("rd1_mosi_bits", 32'(last_bits),  32'(exp_bits));
        check("rd1_pulses",    32'(rd_pulses - pulses0), 32'd1);
        check("rd1_addr",      32'(rd_addr),    32'h199);
        check("rd1_data",      32'(rd_data),    32'hFFFF);

        // Read with a shifted pattern.
        miso_word = 16'h5A3C; MISO = 1'b0;
        push(1'b0, 'h0A5, 'h0);
        wait_quiet("rd2_done");
        check("rd2_addr", 32'(rd_addr), 32'h0A5);
        check("rd2_data", 32'(rd_data), 32'h5A3C);

        // Hold cmd_valid for 10 cycles: one frame in flight plus a full FIFO.
        falls0 = ss_falls;
        miso_word = 16'h1234;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = 1'b1;
            cmd_write = (i % 3) != 1;
            cmd_addr  = ADDR_W'(32'h100 + i);
            cmd_wdata = DATA_W'(32'h1111 * (i + 1));
            if (cmd_ready) acc++;
            @(negedge clk_input);
        end
        cmd_valid = 1'b0;
        check("fill_accepted", 32'(acc),        32'd9);
        check("fill_ready",    32'(cmd_ready),  32'd0);
        check("fill_level",    32'(fifo_level), 32'd8);

        // Offer a push across the pop of the full FIFO.
        guard = 0;
        while (!SS_N && guard < 300) begin @(negedge clk_input); guard++; end
        if (guard >= 300) fail_now("f1_end");
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h1FF; cmd_wdata = 16'hBEEF;
        guard = 0;
        @(negedge clk_input);
        while (SS_N && guard < 50) begin @(negedge clk_input); guard++; end
        if (guard >= 50) fail_now("f2_start");
        check("popfull_ready", 32'(cmd_ready),  32'd1);
        check("popfull_level", 32'(fifo_level), 32'd7);
        @(negedge clk_input);
        cmd_valid = 1'b0;
        check("repush_level",  32'(fifo_level), 32'd8);
        check("repush_ready",  32'(cmd_ready),  32'd0);
        wait_quiet("b2b_done");
        check("b2b_frames", 32'(ss_falls - falls0), 32'd10);
        check("b2b_gap",    32'(last_gap),          32'(SS_GAP));

        // Reset during SHIFT with three entries queued.
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_write = i[0]; cmd_addr = ADDR_W'(32'h40 + i); cmd_wdata = 16'h0F0F;
            @(negedge clk_input);
        end
        cmd_valid = 1'b0;
        guard = 0;
        while (!(SCLK && fifo_level == 3) && guard < 100) begin @(negedge clk_input); guard++; end
        if (guard >= 100) fail_now("mid_shift");
        #2 reset_n = 1'b0;
        #1;
        check("arst_ss_n",  32'(SS_N),       32'd1);
        check("arst_sclk",  32'(SCLK),       32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_busy",  32'(busy),       32'd0);
        tick(2);
        reset_n = 1'b1;
        falls0 = ss_falls;
        tick(300);
        check("post_rst_frames", 32'(ss_falls - falls0), 32'd0);
        check("post_rst_level",  32'(fifo_level),        32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
